// File: rtl/adc_lvds_emulator_if.sv
// External sample stream into the ADC LVDS emulator: one word set per frame.
// Transfer happens in the emulator's load cycle when ext_valid && ext_ready.
// Source holds ext_data/ext_valid; ready is only offered in a mode-3 load cycle.
interface adc_lvds_emulator_if #(
   parameter int BITS  = 12,
   parameter int LANES = 4
);
   logic [LANES*BITS-1:0] ext_data;
   logic                  ext_valid;
   logic                  ext_ready;

   modport master (output ext_data, output ext_valid, input ext_ready);
   modport slave  (input ext_data, input ext_valid, output ext_ready);
endinterface

// File: rtl/adc_lvds_emulator.sv
// Emulates one multi-lane ADC LVDS transmitter: serial lanes MSB first, dco, fco.
// Latency: first MSB one cycle after the load cycle; 2 cycles per bit, no gap between frames.
// Backpressure: none downstream; ext_ready offered only in mode-3 load cycles, missing data -> underrun.
module adc_lvds_emulator #(
   parameter int BITS  = 12,
   parameter int LANES = 4
) (
   input  logic                 sys_clk,
   input  logic                 user_reset,
   input  logic                 enable,
   input  logic [1:0]           mode,
   input  logic [BITS-1:0]      fixed_word,
   input  logic                 underrun_clr,
   adc_lvds_emulator_if.slave   ext,
   output logic [LANES-1:0]     lane_out,
   output logic                 adc_dco,
   output logic                 adc_fco,
   output logic [15:0]          frame_count,
   output logic                 underrun
);
   localparam int IW = $clog2(BITS);
   localparam logic [IW-1:0]   LAST_BIT = IW'(BITS - 1);
   localparam logic [IW-1:0]   HALF_BIT = IW'(BITS / 2);
   localparam logic [BITS-1:0] ALT_HI   = {(BITS/2){2'b10}};

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t               state_q, state_d;
   logic [IW-1:0]        bit_idx_q, bit_idx_d;
   logic                 phase_q, phase_d;
   logic [BITS-1:0]      shreg_q [LANES];
   logic [BITS-1:0]      shreg_d [LANES];
   logic [BITS-1:0]      ramp_q [LANES];
   logic [BITS-1:0]      ramp_d [LANES];
   logic [BITS-1:0]      last_ext_q [LANES];
   logic [BITS-1:0]      last_ext_d [LANES];
   logic [15:0]          frame_count_q, frame_count_d;
   logic                 underrun_q, underrun_d;
   logic [LANES-1:0]     lane_out_q, lane_out_d;
   logic                 dco_q, dco_d;
   logic                 fco_q, fco_d;
   logic                 frame_end;
   logic                 load;

   // Load cycle detection; ready is offered only when the external stream is the source.
   always_comb begin
      frame_end     = (state_q == SHIFT) && (bit_idx_q == LAST_BIT) && phase_q;
      load          = enable && ((state_q == IDLE) || frame_end);
      ext.ext_ready = load && (mode == 2'd3);
   end

   // Next state: bit/phase sequencing, word loading per source, and the registered line outputs.
   always_comb begin
      state_d       = state_q;
      bit_idx_d     = bit_idx_q;
      phase_d       = phase_q;
      shreg_d       = shreg_q;
      ramp_d        = ramp_q;
      last_ext_d    = last_ext_q;
      frame_count_d = frame_count_q;
      underrun_d    = underrun_q;
      lane_out_d    = '0;
      dco_d         = 1'b0;
      fco_d         = 1'b0;

      if (state_q == SHIFT) begin
         if (!phase_q) begin
            phase_d = 1'b1;
         end else if (!frame_end) begin
            phase_d   = 1'b0;
            bit_idx_d = bit_idx_q + IW'(1);
            for (int k = 0; k < LANES; k++) shreg_d[k] = shreg_q[k] << 1;
         end else begin
            // Frame finished without a new load: park until enabled again.
            state_d   = IDLE;
            phase_d   = 1'b0;
            bit_idx_d = '0;
         end
      end

      // Clear first so a same-cycle underrun set overrides it.
      if (underrun_clr) underrun_d = 1'b0;

      if (load) begin
         state_d       = SHIFT;
         bit_idx_d     = '0;
         phase_d       = 1'b0;
         frame_count_d = frame_count_q + 16'd1;
         for (int k = 0; k < LANES; k++) begin
            case (mode)
               2'd0: shreg_d[k] = fixed_word;
               2'd1: begin
                  shreg_d[k] = ramp_q[k];
                  ramp_d[k]  = ramp_q[k] + BITS'(1);
               end
               2'd2: shreg_d[k] = frame_count_q[0] ? ~ALT_HI : ALT_HI;
               default: begin
                  if (ext.ext_valid) begin
                     shreg_d[k]    = ext.ext_data[k*BITS +: BITS];
                     last_ext_d[k] = ext.ext_data[k*BITS +: BITS];
                  end else begin
                     shreg_d[k] = last_ext_q[k];
                  end
               end
            endcase
         end
         if ((mode == 2'd3) && !ext.ext_valid) underrun_d = 1'b1;
      end

      // Outputs are derived from next state so they line up with the registered counters.
      if (state_d == SHIFT) begin
         for (int k = 0; k < LANES; k++) lane_out_d[k] = shreg_d[k][BITS-1];
         dco_d = phase_d;
         fco_d = (bit_idx_d < HALF_BIT);
      end
   end

   // State and output registers; async reset abandons any frame in flight.
   always_ff @(posedge sys_clk or negedge user_reset) begin
      if (!user_reset) begin
         state_q       <= IDLE;
         bit_idx_q     <= '0;
         phase_q       <= 1'b0;
         frame_count_q <= '0;
         underrun_q    <= 1'b0;
         lane_out_q    <= '0;
         dco_q         <= 1'b0;
         fco_q         <= 1'b0;
         for (int k = 0; k < LANES; k++) begin
            shreg_q[k]    <= '0;
            ramp_q[k]     <= BITS'(k);
            last_ext_q[k] <= '0;
         end
      end else begin
         state_q       <= state_d;
         bit_idx_q     <= bit_idx_d;
         phase_q       <= phase_d;
         frame_count_q <= frame_count_d;
         underrun_q    <= underrun_d;
         lane_out_q    <= lane_out_d;
         dco_q         <= dco_d;
         fco_q         <= fco_d;
         shreg_q       <= shreg_d;
         ramp_q        <= ramp_d;
         last_ext_q    <= last_ext_d;
      end
   end

   assign lane_out    = lane_out_q;
   assign adc_dco     = dco_q;
   assign adc_fco     = fco_q;
   assign frame_count = frame_count_q;
   assign underrun    = underrun_q;
endmodule
